canvas_sampler: RTL and testbench
=================================

// Module: canvas_sampler
// PURPOSE
//  Reads back the black/white canvas held in the LCD frame RAM (written by the painter via the graphic
//  manager) and reduces a square region of interest to an OUT_DIM x OUT_DIM image for the classifier.
//  Each output pixel summarises one BLOCK x BLOCK tile. Output is row-major, one pixel per valid/ready beat.
//  Sits between the frame RAM read port and the neural-network input buffer.
// PARAMETERS
//  PIXEL_NUM        76800  frame size in pixels; ram_addr width = $clog2(PIXEL_NUM) = 17
//  COL_NUM          320    frame columns; pixel address = row*COL_NUM + col
//  ROW_NUM          240    frame rows
//  BLOCK            8      tile edge in frame pixels, power of 2
//  OUT_DIM          28     output image edge; OUT_DIM*OUT_DIM = 784 beats per frame
//  COL_OFFSET       48     first ROI column; COL_OFFSET + OUT_DIM*BLOCK <= COL_NUM
//  ROW_OFFSET       8      first ROI row;    ROW_OFFSET + OUT_DIM*BLOCK <= ROW_NUM
//  THRESHOLD        16     white-pixel count at or above which a tile reads as white (binary mode)
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   one-cycle pulse: sample the current frame
//  busy       out  1   high from the cycle after an accepted start until done
//  done       out  1   one-cycle pulse after the last beat is accepted
//  ram_rd     out  1   frame RAM read strobe
//  ram_addr   out  17  frame RAM read address
//  ram_q      in   1   frame RAM data, valid exactly 1 cycle after ram_rd (1 = white)
//  out_valid  out  1   output pixel valid
//  out_ready  in   1   downstream accepts when out_valid && out_ready
//  out_data   out  8   output pixel value
//  out_last   out  1   high with the beat for output index 783 (last pixel)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, ram_rd, out_valid, out_last = 0; ram_addr, out_data = 0; counters = 0.
//  FSM states: IDLE, READ, DRAIN, OUTPUT, DONE.
//   IDLE:   start -> READ, clearing tile row/col, pixel row/col and the accumulator. Otherwise stay.
//   READ:   ram_rd = 1 every cycle. Address for tile (tr,tc), pixel (r,c) =
//           (ROW_OFFSET + tr*BLOCK + r)*COL_NUM + COL_OFFSET + tc*BLOCK + c. c is inner loop, r outer.
//           The accumulator adds ram_q one cycle after each read. It is 7 bits wide, range 0..64.
//           After BLOCK*BLOCK = 64 reads -> DRAIN.
//   DRAIN:  ram_rd = 0; the last ram_q is accumulated -> OUTPUT.
//   OUTPUT: out_valid = 1. out_data and out_last stay stable until the handshake.
//           On the handshake: clear the accumulator and advance tc, wrapping to 0 and incrementing tr.
//           If the beat was the last (tr = tc = OUT_DIM-1) -> DONE, else -> READ.
//   DONE:   done = 1 for one cycle -> IDLE.
//  Timing: minimum 66 cycles per tile (64 READ, 1 DRAIN, >= 1 OUTPUT); 51744 cycles per frame with out_ready held high.
//  out_ready low stalls in OUTPUT indefinitely. No RAM reads are issued while stalled.
//  start while busy is ignored. start in the DONE cycle is also ignored.
//  Reset asserted mid-operation aborts immediately to IDLE. No done pulse is produced; the partial frame is discarded.
//  Arithmetic: address computed in 17 bits. Tile and pixel counters have no wrap beyond their stated ranges.
// CONFIGURATION
//  CANVAS_SAMPLER_GRAYSCALE_EN defined:
//   out_data = min(255, count*4), where count is the tile's white-pixel count (0..64); 64 white pixels -> 255.
//  Not defined (binary mode):
//   out_data = 8'hFF if count >= THRESHOLD, else 8'h00.
//  All timing and handshakes are identical in both builds.
// TESTING
//  1 All-white frame, start, out_ready=1 -> 784 beats of 8'hFF (both builds); out_last on beat 783;
//    done 1 cycle after beat 783 is accepted; total 51744 cycles.
//  2 Address check -> first ram_addr 2608; 64th ram_addr 4855 (=15*320+55); final ram_addr 74191.
//  3 Only pixel (col 48,row 8) white -> beat 0 = 8'h00 in binary build, 8'h04 in grayscale build; all others 0.
//  4 Tile 0 with exactly 16 white pixels -> binary 8'hFF; 15 white pixels -> 8'h00; grayscale builds give 64 and 60.
//  5 out_ready low for 100 cycles at beat 5 -> out_valid, out_data held; ram_rd low throughout; beat order unchanged.
//  6 Reset asserted during READ of tile 300 -> next cycle all outputs at reset values; no done pulse;
//    a new start gives a full 784-beat frame. A start pulse while busy has no effect.

Source files
------------

// File: rtl/canvas_sampler.sv
// rtl/canvas_sampler.sv - reduce a frame-RAM region of interest to an OUT_DIM x OUT_DIM image
//
// Reads BLOCK x BLOCK tiles of the black/white canvas from the frame RAM and
// emits one summarised pixel per tile, row-major, over a valid/ready stream.
// Optional build macro: CANVAS_SAMPLER_GRAYSCALE_EN
//   defined     -> out_data = min(255, white_count*4)
//   not defined -> out_data = 8'hFF when white_count >= THRESHOLD, else 8'h00
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   start      in   one-cycle pulse, sample the current frame (ignored unless idle)
//   busy       out  frame in progress (READ / DRAIN / OUTPUT)
//   done       out  one-cycle pulse after the last beat is accepted
//   ram_rd     out  frame RAM read strobe
//   ram_addr   out  frame RAM read address (0 when not reading)
//   ram_q      in   frame RAM data, valid one cycle after ram_rd (1 = white)
//   out_valid  out  output pixel valid
//   out_ready  in   downstream ready
//   out_data   out  output pixel value
//   out_last   out  marks the final pixel of the image
module canvas_sampler #(
  parameter int PIXEL_NUM  = 76800,
  parameter int COL_NUM    = 320,
  parameter int ROW_NUM    = 240,
  parameter int BLOCK      = 8,
  parameter int OUT_DIM    = 28,
  parameter int COL_OFFSET = 48,
  parameter int ROW_OFFSET = 8,
  parameter int THRESHOLD  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         ram_rd,
  output logic [$clog2(PIXEL_NUM)-1:0] ram_addr,
  input  logic                         ram_q,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last
);

  localparam int ADDR_W = $clog2(PIXEL_NUM);
  localparam int ROW_W  = $clog2(ROW_NUM);
  localparam int COL_W  = $clog2(COL_NUM);
  localparam int PIX_W  = $clog2(BLOCK);
  localparam int TILE_W = $clog2(OUT_DIM);
  localparam int ACC_W  = $clog2(BLOCK * BLOCK + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(BLOCK - 1);
  localparam logic [TILE_W-1:0] TILE_LAST = TILE_W'(OUT_DIM - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_OUTPUT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [TILE_W-1:0] tile_row;
  logic [TILE_W-1:0] tile_col;
  logic [PIX_W-1:0]  pix_row;
  logic [PIX_W-1:0]  pix_col;
  logic [ACC_W-1:0]  acc;
  logic              rd_pending;   // a read was issued last cycle, so ram_q is valid now
  logic [ROW_W-1:0]  frame_row;
  logic [COL_W-1:0]  frame_col;
  logic [7:0]        pixel_value;

  always_comb begin
    frame_row = ROW_W'(ROW_OFFSET) + ROW_W'(tile_row) * ROW_W'(BLOCK) + ROW_W'(pix_row);
    frame_col = COL_W'(COL_OFFSET) + COL_W'(tile_col) * COL_W'(BLOCK) + COL_W'(pix_col);
  end

`ifdef CANVAS_SAMPLER_GRAYSCALE_EN
  logic [ACC_W+1:0] scaled;
  assign scaled = {acc, 2'b00};

  // A fully white tile scales to 256, which saturates to 255.
  always_comb begin
    pixel_value = 8'h00;
    if (scaled > (ACC_W + 2)'(255)) begin
      pixel_value = 8'hFF;
    end else begin
      pixel_value = scaled[7:0];
    end
  end
`else
  always_comb begin
    pixel_value = 8'h00;
    if (acc >= ACC_W'(THRESHOLD)) begin
      pixel_value = 8'hFF;
    end
  end
`endif

  // All outputs decode from registered state, so an asynchronous reset
  // returns them to zero immediately.
  assign busy      = (state == S_READ) || (state == S_DRAIN) || (state == S_OUTPUT);
  assign done      = (state == S_DONE);
  assign ram_rd    = (state == S_READ);
  assign ram_addr  = (state == S_READ) ?
                     ADDR_W'(frame_row) * ADDR_W'(COL_NUM) + ADDR_W'(frame_col) : '0;
  assign out_valid = (state == S_OUTPUT);
  assign out_data  = (state == S_OUTPUT) ? pixel_value : 8'h00;
  assign out_last  = (state == S_OUTPUT) && (tile_row == TILE_LAST) && (tile_col == TILE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tile_row   <= '0;
      tile_col   <= '0;
      pix_row    <= '0;
      pix_col    <= '0;
      acc        <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= (state == S_READ);
      if (rd_pending) begin
        acc <= acc + ACC_W'(ram_q);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_READ;
            tile_row <= '0;
            tile_col <= '0;
            pix_row  <= '0;
            pix_col  <= '0;
            acc      <= '0;
          end
        end

        // Column is the inner loop; the last read of a tile moves to DRAIN
        // so its data, arriving one cycle late, still lands in the count.
        S_READ: begin
          if (pix_col == PIX_LAST) begin
            pix_col <= '0;
            if (pix_row == PIX_LAST) begin
              pix_row <= '0;
              state   <= S_DRAIN;
            end else begin
              pix_row <= pix_row + 1'b1;
            end
          end else begin
            pix_col <= pix_col + 1'b1;
          end
        end

        S_DRAIN: begin
          state <= S_OUTPUT;
        end

        S_OUTPUT: begin
          if (out_ready) begin
            acc <= '0;
            if (tile_col == TILE_LAST) begin
              tile_col <= '0;
              if (tile_row == TILE_LAST) begin
                tile_row <= '0;
                state    <= S_DONE;
              end else begin
                tile_row <= tile_row + 1'b1;
                state    <= S_READ;
              end
            end else begin
              tile_col <= tile_col + 1'b1;
              state    <= S_READ;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_canvas_sampler.sv
// tb/tb_canvas_sampler.sv - directed self-checking bench for canvas_sampler
`timescale 1ns/1ps
module tb_canvas_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        ram_rd;
  logic [16:0] ram_addr;
  logic        ram_q = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  logic       mem     [0:76799];
  logic [7:0] exp_pix [0:783];

  canvas_sampler dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_q     (ram_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Frame RAM: one-cycle read latency.
  always @(posedge clk) ram_q <= ram_rd ? mem[ram_addr] : ram_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_ram_rd"},    ram_rd,    0);
    check({tag, "_ram_addr"},  ram_addr,  0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
  endtask

  initial begin
    int          cyc;
    int          beats;
    int          nreads;
    int          done_cnt;
    int          stall_left;
    int          elapsed;
    logic [16:0] first_addr;
    logic [16:0] addr64;
    logic [16:0] last_addr;
    logic [7:0]  held;
    logic        seen_done;
    logic        stall_used;

    reset     = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    first_addr = '0;
    addr64     = '0;
    last_addr  = '0;
    held       = '0;

    // Canvas: all white, except tiles 0..3 of the first tile row.
    // tile0: only pixel (col 48,row 8); tile1: 16 whites; tile2: 15 whites; tile3: none.
    for (int i = 0; i < 76800; i++) mem[i] = 1'b1;
    for (int r = 8; r < 16; r++)
      for (int c = 48; c < 80; c++) mem[r*320 + c] = 1'b0;
    mem[8*320 + 48] = 1'b1;
    for (int c = 56; c < 64; c++) begin
      mem[8*320 + c] = 1'b1;
      mem[9*320 + c] = 1'b1;
    end
    for (int c = 64; c < 72; c++) mem[8*320 + c] = 1'b1;
    for (int c = 64; c < 71; c++) mem[9*320 + c] = 1'b1;

    for (int i = 0; i < 784; i++) exp_pix[i] = 8'hFF;
`ifdef CANVAS_SAMPLER_GRAYSCALE_EN
    exp_pix[0] = 8'h04;
    exp_pix[1] = 8'h40;
    exp_pix[2] = 8'h3C;
    exp_pix[3] = 8'h00;
`else
    exp_pix[0] = 8'h00;
    exp_pix[1] = 8'hFF;
    exp_pix[2] = 8'h00;
    exp_pix[3] = 8'h00;
`endif

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Abort mid-frame: reset during READ of tile 300.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_rd", ram_rd, 1);
    beats = 0;
    cyc   = 0;
    while (cyc < 25000 && !(beats == 300 && ram_rd)) begin
      if (out_valid && out_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    check("reach_tile300", cyc < 25000, 1);
    repeat (10) @(negedge clk);
    check("tile300_reading", ram_rd, 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy, 0);

    // Full frame with a 100-cycle stall at beat 5 and a start pulse while busy.
    start = 1'b1;
    @(negedge clk);
    elapsed    = 0;
    beats      = 0;
    nreads     = 0;
    stall_left = 0;
    stall_used = 1'b0;
    seen_done  = 1'b0;
    while (!seen_done && elapsed < 60000) begin
      start = (elapsed == 10);
      if (ram_rd) begin
        nreads++;
        if (nreads == 1)  first_addr = ram_addr;
        if (nreads == 64) addr64     = ram_addr;
        last_addr = ram_addr;
      end
      if (stall_left > 0) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
        check("stall_rd", ram_rd, 0);
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (out_valid && beats == 5 && !stall_used) begin
        stall_used = 1'b1;
        stall_left = 100;
        held       = out_data;
        out_ready  = 1'b0;
      end
      if (out_valid && out_ready) begin
        check($sformatf("beat%0d_data", beats), out_data, exp_pix[beats]);
        check($sformatf("beat%0d_last", beats), out_last, beats == 783);
        beats++;
      end
      if (done) begin
        seen_done = 1'b1;
      end else begin
        @(negedge clk);
        elapsed++;
      end
    end
    check("frame_done_seen", seen_done, 1);
    check("frame_cycles", elapsed, 51744 + 100);
    check("frame_beats", beats, 784);
    check("frame_reads", nreads, 784 * 64);
    check("addr_first", first_addr, 2608);
    check("addr_64th", addr64, 4855);
    check("addr_last", last_addr, 74191);

    // start during the DONE cycle must not launch a new frame.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_width", done, 0);
    check("start_in_done_ignored", busy, 0);
    check("idle_no_rd", ram_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
